// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: routing modes, the default
// error-counter width and the round-robin pointer advance.
package demux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int ERR_W_DEFAULT = 8;

  // Wraps to 0 at n_ch-1, and also pulls any out-of-range pointer back to 0.
  function automatic int unsigned rr_advance(input int unsigned ptr, input int unsigned n_ch);
    if (ptr + 32'd1 >= n_ch) return 32'd0;
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
// A load in the same cycle as a drain keeps the slot full with the new word.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = load | (full_q & ~drain);
    data_d = load ? load_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign data = data_q;
  assign full = full_q;

endmodule

// File: rtl/demultiplexor_stream.sv
// Registered 1-to-N stream demultiplexer: directed or round-robin routing into
// per-channel holding slots, with invalid-select drop counting.
module demultiplexor_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int N_CH  = 2,
  parameter int SEL_W = 1,
  parameter int ERR_W = ERR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [SEL_W-1:0]      rr_ptr,
  output logic                  sel_err,
  output logic [ERR_W-1:0]      err_cnt
);

  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             sel_err_q, sel_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [SEL_W-1:0] tgt;
  logic             tgt_ok;
  logic             accept;
  logic [N_CH-1:0]  load;
  logic [N_CH-1:0]  slot_full;
  logic [WIDTH-1:0] slot_data [N_CH];

  always_comb begin
    tgt    = (mode == MODE_RR) ? rr_ptr_q : in_sel;
    tgt_ok = int'(tgt) < N_CH;

    // Only a stalled target slot blocks; invalid targets are always taken and dropped.
    in_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(tgt) == i && slot_full[i] && !out_ready[i]) in_ready = 1'b0;
    end

    accept = in_valid && in_ready;

    load = '0;
    for (int i = 0; i < N_CH; i++) begin
      load[i] = accept && (int'(tgt) == i);
    end

    rr_ptr_d = rr_ptr_q;
    if (accept && mode == MODE_RR) begin
      rr_ptr_d = SEL_W'(rr_advance(32'(rr_ptr_q), 32'(N_CH)));
    end

    sel_err_d = accept && !tgt_ok;

    err_cnt_d = err_cnt_q;
    if (sel_err_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      sel_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      sel_err_q <= sel_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[g]),
      .load_data (in_data),
      .drain     (out_ready[g]),
      .data      (slot_data[g]),
      .full      (slot_full[g])
    );
    assign out_data[g*WIDTH +: WIDTH] = slot_data[g];
  end

  assign out_valid = slot_full;
  assign rr_ptr    = rr_ptr_q;
  assign sel_err   = sel_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_demultiplexor_stream.sv
// Bench for demultiplexor_stream (3 channels, 2-bit select, 8-bit words):
// table-driven vectors plus hand sequences, checked against a behavioural model and per-channel scoreboards.
module tb_demultiplexor_stream;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam int EW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            mode;
  logic [W-1:0]    in_data;
  logic [SW-1:0]   in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [N*W-1:0]  out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [SW-1:0]   rr_ptr;
  logic            sel_err;
  logic [EW-1:0]   err_cnt;

  always #5 clk = ~clk;

  demultiplexor_stream #(
    .WIDTH(W), .N_CH(N), .SEL_W(SW), .ERR_W(EW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rr_ptr    (rr_ptr),
    .sel_err   (sel_err),
    .err_cnt   (err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] m_full;
  int           m_rr;
  int           m_err;
  logic         m_selerr;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [W-1:0] q2[$];

  typedef struct {
    logic       md;
    logic [1:0] sel;
    logic [7:0] dat;
    logic       vld;
    logic [2:0] rdy;
    logic       exp_rdy;
    logic [2:0] exp_ov;
    logic [1:0] exp_rr;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_push(input int ch, input logic [W-1:0] d);
    case (ch)
      0: q0.push_back(d);
      1: q1.push_back(d);
      default: q2.push_back(d);
    endcase
  endtask

  task automatic sb_pop(input int ch, input logic [W-1:0] act);
    logic [W-1:0] exp;
    int           sz;
    case (ch)
      0: sz = q0.size();
      1: sz = q1.size();
      default: sz = q2.size();
    endcase
    if (sz == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_spurious ch%0d: got 0x%0h, expected no delivery", ch, act);
    end else begin
      case (ch)
        0: exp = q0.pop_front();
        1: exp = q1.pop_front();
        default: exp = q2.pop_front();
      endcase
      check($sformatf("out_data ch%0d", ch), 32'(act), 32'(exp));
    end
  endtask

  // One clock cycle with the currently driven inputs; model updated from the spec rules.
  task automatic tick();
    int           t;
    logic         tv, er, acc;
    logic [N-1:0] nf;
    #1;
    t  = mode ? m_rr : int'(in_sel);
    tv = (t < N);
    er = !tv || !m_full[t] || out_ready[t];
    check("in_ready", 32'(in_ready), 32'(er));
    check("out_valid", 32'(out_valid), 32'(m_full));
    for (int i = 0; i < N; i++) begin
      if (out_valid[i] && out_ready[i]) sb_pop(i, out_data[i*W +: W]);
    end
    acc = in_valid && er;
    nf  = m_full & ~out_ready;
    if (acc && tv) begin
      nf[t] = 1'b1;
      sb_push(t, in_data);
    end
    m_full   = nf;
    m_selerr = acc && !tv;
    if (m_selerr && m_err < 255) m_err++;
    if (acc && mode) m_rr = (m_rr + 1) % N;
    @(posedge clk);
    #1;
    check("rr_ptr", 32'(rr_ptr), 32'(m_rr));
    check("sel_err", 32'(sel_err), 32'(m_selerr));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = '0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    m_full   = '0;
    m_rr     = 0;
    m_err    = 0;
    m_selerr = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst rr_ptr", 32'(rr_ptr), 32'd0);
    check("rst err_cnt", 32'(err_cnt), 32'd0);
    check("rst sel_err", 32'(sel_err), 32'd0);
  endtask

  task automatic drive(input logic md, input logic [1:0] sel, input logic [7:0] dat,
                       input logic vld, input logic [2:0] rdy);
    mode      = md;
    in_sel    = sel;
    in_data   = dat;
    in_valid  = vld;
    out_ready = rdy;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
    m_full = '0; m_rr = 0; m_err = 0; m_selerr = 1'b0;

    //            md    sel    dat    vld   rdy     rdy   ov      rr
    tbl[0]  = '{1'b0, 2'd2, 8'hA1, 1'b1, 3'b111, 1'b1, 3'b100, 2'd0};
    tbl[1]  = '{1'b0, 2'd0, 8'hB2, 1'b1, 3'b111, 1'b1, 3'b001, 2'd0};
    tbl[2]  = '{1'b0, 2'd0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b000, 2'd0};
    tbl[3]  = '{1'b1, 2'd0, 8'h01, 1'b1, 3'b111, 1'b1, 3'b001, 2'd1};
    tbl[4]  = '{1'b1, 2'd0, 8'h02, 1'b1, 3'b111, 1'b1, 3'b010, 2'd2};
    tbl[5]  = '{1'b1, 2'd0, 8'h03, 1'b1, 3'b111, 1'b1, 3'b100, 2'd0};
    tbl[6]  = '{1'b1, 2'd0, 8'h04, 1'b1, 3'b111, 1'b1, 3'b001, 2'd1};
    tbl[7]  = '{1'b1, 2'd0, 8'h05, 1'b1, 3'b111, 1'b1, 3'b010, 2'd2};
    tbl[8]  = '{1'b1, 2'd0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b000, 2'd2};
    tbl[9]  = '{1'b0, 2'd0, 8'h55, 1'b1, 3'b110, 1'b1, 3'b001, 2'd2};
    tbl[10] = '{1'b0, 2'd0, 8'h66, 1'b1, 3'b111, 1'b1, 3'b001, 2'd2};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b000, 2'd2};

    do_reset();

    // Directed fill/drain, round-robin wrap, same-cycle drain and reload.
    for (int r = 0; r < 12; r++) begin
      drive(tbl[r].md, tbl[r].sel, tbl[r].dat, tbl[r].vld, tbl[r].rdy);
      #1;
      check($sformatf("tbl%0d in_ready", r), 32'(in_ready), 32'(tbl[r].exp_rdy));
      tick();
      check($sformatf("tbl%0d out_valid", r), 32'(out_valid), 32'(tbl[r].exp_ov));
      check($sformatf("tbl%0d rr_ptr", r), 32'(rr_ptr), 32'(tbl[r].exp_rr));
    end

    // Backpressure isolation: ch1 stalled, ch2 still accepted.
    drive(1'b0, 2'd1, 8'h11, 1'b1, 3'b101); tick();
    drive(1'b0, 2'd1, 8'h22, 1'b1, 3'b101); tick();
    check("bp_stall in_ready", 32'(in_ready), 32'd0);
    tick();
    drive(1'b0, 2'd2, 8'h33, 1'b1, 3'b101); tick();
    drive(1'b0, 2'd1, 8'h22, 1'b1, 3'b111); tick();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 3'b111); tick(); tick();

    // Invalid select: drops, error pulses, counter saturates.
    for (int k = 0; k < 300; k++) begin
      drive(1'b0, 2'd3, 8'(k), 1'b1, 3'b111);
      tick();
    end
    drive(1'b0, 2'd0, 8'h00, 1'b0, 3'b111); tick();
    check("err_cnt saturated", 32'(err_cnt), 32'd255);

    // Reset with slots 0 and 2 full and rr_ptr at 2; held words must vanish.
    drive(1'b1, 2'd0, 8'hC0, 1'b1, 3'b000); tick();
    drive(1'b1, 2'd0, 8'hC1, 1'b1, 3'b000); tick();
    drive(1'b1, 2'd0, 8'hC2, 1'b1, 3'b010); tick();
    drive(1'b1, 2'd0, 8'h00, 1'b0, 3'b010); tick();
    check("pre-reset out_valid", 32'(out_valid), 32'b101);
    check("pre-reset rr_ptr", 32'(rr_ptr), 32'd2);
    do_reset();
    drive(1'b0, 2'd0, 8'h00, 1'b0, 3'b111);
    for (int k = 0; k < 3; k++) tick();

    check("sb ch0 empty", 32'(q0.size()), 32'd0);
    check("sb ch1 empty", 32'(q1.size()), 32'd0);
    check("sb ch2 empty", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
